// File: rtl/wired_rf_read_stage_if.sv
// Issue-side and execute-side handshake bundle for the register-read stage.
// master: the side that issues ops and consumes operands; slave: the stage.
interface wired_rf_read_stage_if #(
   parameter int WIDTH  = 32,
   parameter int META_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [4:0]        in_rs0;
   logic [4:0]        in_rs1;
   logic [4:0]        in_rs2;
   logic [4:0]        in_rd;
   logic              in_rd_we;
   logic [META_W-1:0] in_meta;

   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_op0;
   logic [WIDTH-1:0]  out_op1;
   logic [WIDTH-1:0]  out_op2;
   logic [4:0]        out_rd;
   logic              out_rd_we;
   logic [META_W-1:0] out_meta;

   modport master (
      output in_valid, in_rs0, in_rs1, in_rs2, in_rd, in_rd_we, in_meta, out_ready,
      input  in_ready, out_valid, out_op0, out_op1, out_op2, out_rd, out_rd_we, out_meta
   );

   modport slave (
      input  in_valid, in_rs0, in_rs1, in_rs2, in_rd, in_rd_we, in_meta, out_ready,
      output in_ready, out_valid, out_op0, out_op1, out_op2, out_rd, out_rd_we, out_meta
   );
endinterface

// File: rtl/wired_rf_read_stage.sv
// Register-read stage in front of a 32x(3R/1W) async-read RAM: operand
// fetch with writeback bypass, per-register busy scoreboard, RAW/WAW stall
// and a registered valid/ready output slot. r0 reads as zero.

// One read port: operand select (zero / bypass / RAM) and source hazard.
module wired_rf_read_port #(
   parameter int WIDTH = 32
) (
   input  logic [4:0]       rs,
   input  logic [WIDTH-1:0] ram_dout,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic [WIDTH-1:0] wb_data,
   input  logic [31:0]      busy_eff,
   output logic [WIDTH-1:0] operand,
   output logic             src_haz
);
   // r0 wins over bypass so a writeback to r0 can never leak into an operand
   always_comb begin
      operand = ram_dout;
      if (rs == 5'd0)
         operand = '0;
      else if (wb_valid && (wb_rd == rs))
         operand = wb_data;
   end

   // busy_eff[0] is always 0, so r0 never stalls
   assign src_haz = busy_eff[rs];
endmodule

module wired_rf_read_stage #(
   parameter int WIDTH  = 32,
   parameter int META_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   wired_rf_read_stage_if.slave bus,
   output logic [4:0]       ram_addr0,
   output logic [4:0]       ram_addr1,
   output logic [4:0]       ram_addr2,
   input  logic [WIDTH-1:0] ram_dout0,
   input  logic [WIDTH-1:0] ram_dout1,
   input  logic [WIDTH-1:0] ram_dout2,
   output logic [4:0]       ram_addrw,
   output logic [WIDTH-1:0] ram_din,
   output logic             ram_wea,
   input  logic             wb_valid,
   input  logic [4:0]       wb_rd,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             flush,
   output logic [4:0]       busy_cnt
);
   localparam int NUM_RD = 3;

   logic [NUM_RD-1:0][4:0]       rs_vec;
   logic [NUM_RD-1:0][WIDTH-1:0] dout_vec;
   logic [NUM_RD-1:0][WIDTH-1:0] op_vec;
   logic [NUM_RD-1:0]            src_haz;

   logic [31:0] busy;
   logic [31:0] busy_eff;
   logic [31:0] busy_nxt;
   logic [31:0] wb_hit;
   logic        dst_haz;
   logic        hazard;
   logic        accept;

   assign rs_vec   = {bus.in_rs2, bus.in_rs1, bus.in_rs0};
   assign dout_vec = {ram_dout2, ram_dout1, ram_dout0};

   // RAM side is pure wiring: reads follow the issue indices, writes follow wb
   assign ram_addr0 = bus.in_rs0;
   assign ram_addr1 = bus.in_rs1;
   assign ram_addr2 = bus.in_rs2;
   assign ram_addrw = wb_rd;
   assign ram_din   = wb_data;
   assign ram_wea   = wb_valid && (wb_rd != 5'd0);

   // A writeback landing this cycle releases its register immediately
   assign wb_hit   = wb_valid ? (32'd1 << wb_rd) : 32'd0;
   assign busy_eff = busy & ~wb_hit;

   genvar g;
   generate
      for (g = 0; g < NUM_RD; g++) begin : g_port
         wired_rf_read_port #(.WIDTH(WIDTH)) u_port (
            .rs       (rs_vec[g]),
            .ram_dout (dout_vec[g]),
            .wb_valid (wb_valid),
            .wb_rd    (wb_rd),
            .wb_data  (wb_data),
            .busy_eff (busy_eff),
            .operand  (op_vec[g]),
            .src_haz  (src_haz[g])
         );
      end
   endgenerate

   assign dst_haz      = bus.in_rd_we && busy_eff[bus.in_rd];
   assign hazard       = bus.in_valid && ((|src_haz) || dst_haz);
   assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard && !flush;
   assign accept       = bus.in_valid && bus.in_ready;

   // Scoreboard next state: wb clears first, an accepted writer then sets (set wins)
   always_comb begin
      busy_nxt = busy & ~wb_hit;
      if (accept && bus.in_rd_we)
         busy_nxt[bus.in_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
      if (flush)
         busy_nxt = '0;
   end

   // Population count over r1..r31; bit 0 is never set so 5 bits suffice
   function automatic logic [4:0] popcnt(input logic [31:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 1; i < 32; i++)
         c = c + 5'(v[i]);
      return c;
   endfunction

   // Busy bits and their registered count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= popcnt(busy_nxt);
      end
   end

   // Output slot: load on accept, drain when consumed, hold while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_op0   <= '0;
         bus.out_op1   <= '0;
         bus.out_op2   <= '0;
         bus.out_rd    <= '0;
         bus.out_rd_we <= 1'b0;
         bus.out_meta  <= '0;
      end else if (flush) begin
         bus.out_valid <= 1'b0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.out_op0   <= op_vec[0];
         bus.out_op1   <= op_vec[1];
         bus.out_op2   <= op_vec[2];
         bus.out_rd    <= bus.in_rd;
         bus.out_rd_we <= bus.in_rd_we;
         bus.out_meta  <= bus.in_meta;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_wired_rf_read_stage.sv
// Bench for wired_rf_read_stage: directed cycle table, async reset check,
// then randomized traffic against a scoreboard-level reference model.
module tb_wired_rf_read_stage;
   localparam int WIDTH  = 32;
   localparam int META_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wired_rf_read_stage_if #(.WIDTH(WIDTH), .META_W(META_W)) bus_if ();

   logic [4:0]       ram_addr0, ram_addr1, ram_addr2, ram_addrw;
   logic [WIDTH-1:0] ram_dout0, ram_dout1, ram_dout2, ram_din;
   logic             ram_wea;
   logic             wb_valid;
   logic [4:0]       wb_rd;
   logic [WIDTH-1:0] wb_data;
   logic             flush;
   logic [4:0]       busy_cnt;

   wired_rf_read_stage #(.WIDTH(WIDTH), .META_W(META_W)) dut (
      .clk(clk), .rst(rst), .bus(bus_if),
      .ram_addr0(ram_addr0), .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
      .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2),
      .ram_addrw(ram_addrw), .ram_din(ram_din), .ram_wea(ram_wea),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .busy_cnt(busy_cnt)
   );

   // Register RAM model: async read, sync write
   logic [WIDTH-1:0] ram [32] = '{5: 32'h11, 6: 32'h22, 7: 32'h33, default: '0};
   assign ram_dout0 = ram[ram_addr0];
   assign ram_dout1 = ram[ram_addr1];
   assign ram_dout2 = ram[ram_addr2];
   always @(posedge clk) if (ram_wea) ram[ram_addrw] <= ram_din;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit iv, input int rs0, rs1, rs2, rd, input bit we,
                        input bit wbv, input int wbrd, input logic [31:0] wbd,
                        input bit ordy, input bit fl, input logic [15:0] meta);
      bus_if.in_valid  = iv;
      bus_if.in_rs0    = 5'(rs0);
      bus_if.in_rs1    = 5'(rs1);
      bus_if.in_rs2    = 5'(rs2);
      bus_if.in_rd     = 5'(rd);
      bus_if.in_rd_we  = we;
      bus_if.in_meta   = meta;
      bus_if.out_ready = ordy;
      wb_valid = wbv;
      wb_rd    = 5'(wbrd);
      wb_data  = wbd;
      flush    = fl;
   endtask

   typedef struct {
      bit iv; int rs0, rs1, rs2, rd; bit we;
      bit wbv; int wbrd; logic [31:0] wbd; bit ordy, fl;
      bit xrdy, xwea, xov; logic [31:0] x0, x1, x2; int xrd, xcnt;
   } vec_t;

   function automatic vec_t mk(int iv, rs0, rs1, rs2, rd, we, wbv, wbrd, wbd, ordy, fl,
                               xrdy, xwea, xov, x0, x1, x2, xrd, xcnt);
      vec_t v;
      v.iv = bit'(iv); v.rs0 = rs0; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = bit'(we);
      v.wbv = bit'(wbv); v.wbrd = wbrd; v.wbd = 32'(wbd); v.ordy = bit'(ordy); v.fl = bit'(fl);
      v.xrdy = bit'(xrdy); v.xwea = bit'(xwea); v.xov = bit'(xov);
      v.x0 = 32'(x0); v.x1 = 32'(x1); v.x2 = 32'(x2); v.xrd = xrd; v.xcnt = xcnt;
      return v;
   endfunction

   // Reference model state (scoreboard view)
   bit               m_busy [32];
   bit               m_ov;
   logic [WIDTH-1:0] m_op [3];
   logic [4:0]       m_rd;
   logic             m_we;
   logic [15:0]      m_meta;

   function automatic logic [WIDTH-1:0] m_read(input logic [4:0] r);
      if (r == 0) return '0;
      if (wb_valid && wb_rd == r) return wb_data;
      return ram[r];
   endfunction

   function automatic bit m_pending(input logic [4:0] r);
      return r != 0 && m_busy[r] && !(wb_valid && wb_rd == r);
   endfunction

   function automatic int m_count();
      int c = 0;
      foreach (m_busy[i]) c += int'(m_busy[i]);
      return c;
   endfunction

   initial begin
      vec_t vt [15];
      logic [4:0] src [3];
      bit exp_rdy, acc;

      vt[0]  = mk(1,5,6,7,8,1,   0,0,0,     1,0, 1,0, 1,'h11,'h22,'h33,8,1);
      vt[1]  = mk(1,8,0,0,10,0,  0,0,0,     1,0, 0,0, 0,0,0,0,0,1);
      vt[2]  = mk(1,8,0,0,10,0,  1,8,'hAB,  1,0, 1,1, 1,'hAB,0,0,10,0);
      vt[3]  = mk(1,0,0,0,0,1,   1,0,'h55,  1,0, 1,0, 1,0,0,0,0,0);
      vt[4]  = mk(1,5,0,0,11,1,  0,0,0,     0,0, 0,0, 1,0,0,0,0,0);
      vt[5]  = mk(1,5,0,0,11,1,  0,0,0,     0,0, 0,0, 1,0,0,0,0,0);
      vt[6]  = mk(1,5,0,0,11,1,  0,0,0,     0,0, 0,0, 1,0,0,0,0,0);
      vt[7]  = mk(1,5,0,0,11,1,  0,0,0,     1,0, 1,0, 1,'h11,0,0,11,1);
      vt[8]  = mk(1,6,7,0,12,1,  0,0,0,     1,0, 1,0, 1,'h22,'h33,0,12,2);
      vt[9]  = mk(1,5,5,5,9,1,   1,9,'h77,  1,0, 1,1, 1,'h11,'h11,'h11,9,3);
      vt[10] = mk(1,0,0,0,9,1,   0,0,0,     1,0, 0,0, 0,0,0,0,0,3);
      vt[11] = mk(1,0,0,0,9,1,   1,9,'h99,  1,0, 1,1, 1,0,0,0,9,3);
      vt[12] = mk(1,0,0,0,13,1,  0,0,0,     1,0, 1,0, 1,0,0,0,13,4);
      vt[13] = mk(1,0,0,0,14,1,  1,5,'h5A,  1,1, 0,1, 0,0,0,0,0,0);
      vt[14] = mk(1,9,11,5,9,1,  0,0,0,     1,0, 1,0, 1,'h99,0,'h5A,9,1);

      drive(0,0,0,0,0,0, 0,0,0, 1,0, 16'h0);
      #12;
      chk("reset out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("reset busy_cnt",  64'(busy_cnt), 64'd0);
      chk("reset out_op0",   64'(bus_if.out_op0), 64'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Directed table: in_ready/ram_wea before the edge, slot and count after it
      for (int i = 0; i < 15; i++) begin
         drive(vt[i].iv, vt[i].rs0, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].we,
               vt[i].wbv, vt[i].wbrd, vt[i].wbd, vt[i].ordy, vt[i].fl, 16'(i));
         #3;
         chk($sformatf("v%0d in_ready", i),  64'(bus_if.in_ready), 64'(vt[i].xrdy));
         chk($sformatf("v%0d ram_wea", i),   64'(ram_wea), 64'(vt[i].xwea));
         chk($sformatf("v%0d ram_addr0", i), 64'(ram_addr0), 64'(vt[i].rs0));
         @(posedge clk); #1;
         chk($sformatf("v%0d out_valid", i), 64'(bus_if.out_valid), 64'(vt[i].xov));
         chk($sformatf("v%0d busy_cnt", i),  64'(busy_cnt), 64'(vt[i].xcnt));
         if (vt[i].xov) begin
            chk($sformatf("v%0d op0", i), 64'(bus_if.out_op0), 64'(vt[i].x0));
            chk($sformatf("v%0d op1", i), 64'(bus_if.out_op1), 64'(vt[i].x1));
            chk($sformatf("v%0d op2", i), 64'(bus_if.out_op2), 64'(vt[i].x2));
            chk($sformatf("v%0d out_rd", i), 64'(bus_if.out_rd), 64'(vt[i].xrd));
         end
      end

      // Async reset mid-operation: slot valid and one busy reg, no clock edge
      drive(0,0,0,0,0,0, 0,0,0, 0,0, 16'h0);
      rst = 1'b1;
      #1;
      chk("async rst out_valid", 64'(bus_if.out_valid), 64'd0);
      chk("async rst busy_cnt",  64'(busy_cnt), 64'd0);
      chk("async rst out_rd",    64'(bus_if.out_rd), 64'd0);
      @(posedge clk); #1 rst = 1'b0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_ov = 1'b0;

      // Randomized traffic against the reference model
      for (int c = 0; c < 600; c++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
               $urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom,
               $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, 16'($urandom));
         #3;
         src[0] = bus_if.in_rs0; src[1] = bus_if.in_rs1; src[2] = bus_if.in_rs2;
         exp_rdy = (!m_ov || bus_if.out_ready) && !flush &&
                   !(bus_if.in_valid && (m_pending(src[0]) || m_pending(src[1]) ||
                     m_pending(src[2]) || (bus_if.in_rd_we && m_pending(bus_if.in_rd))));
         chk("rnd in_ready", 64'(bus_if.in_ready), 64'(exp_rdy));
         chk("rnd ram_wea",  64'(ram_wea), 64'(wb_valid && wb_rd != 0));
         acc = bus_if.in_valid && exp_rdy;
         if (flush) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_ov = 1'b0;
         end else begin
            if (wb_valid) m_busy[wb_rd] = 1'b0;
            if (acc) begin
               for (int k = 0; k < 3; k++) m_op[k] = m_read(src[k]);
               m_rd = bus_if.in_rd; m_we = bus_if.in_rd_we; m_meta = bus_if.in_meta;
               if (bus_if.in_rd_we && bus_if.in_rd != 0) m_busy[bus_if.in_rd] = 1'b1;
               m_ov = 1'b1;
            end else if (bus_if.out_ready) begin
               m_ov = 1'b0;
            end
         end
         @(posedge clk); #1;
         chk("rnd out_valid", 64'(bus_if.out_valid), 64'(m_ov));
         chk("rnd busy_cnt",  64'(busy_cnt), 64'(m_count()));
         if (m_ov) begin
            chk("rnd op0",   64'(bus_if.out_op0), 64'(m_op[0]));
            chk("rnd op1",   64'(bus_if.out_op1), 64'(m_op[1]));
            chk("rnd op2",   64'(bus_if.out_op2), 64'(m_op[2]));
            chk("rnd rd",    64'(bus_if.out_rd), 64'(m_rd));
            chk("rnd rd_we", 64'(bus_if.out_rd_we), 64'(m_we));
            chk("rnd meta",  64'(bus_if.out_meta), 64'(m_meta));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
